cla_seq_adder_ctrl: RTL and testbench
=====================================

// Module: cla_seq_adder_ctrl
// PURPOSE
//  Sequences the existing 4-bit carry-lookahead adder (cla) to add two WIDTH-bit operands.
//  Processes one 4-bit slice per clock, low slice first.
//  Carry is held in a register between slices.
//  Uses valid/ready handshakes on input and output.
//  Sits between an operand source and a result consumer; one operation in flight at a time.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; multiple of 4, >= 4
//  NSLICE  WIDTH/4   derived localparam: number of cla passes per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      controller can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry into slice 0
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  sum
//  out_cout   out  1      carry out of top slice
//  busy       out  1      high in RUN or DONE
//  out_ovf    out  1      signed overflow (only with CLA_SEQ_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, slice counter=0, carry reg=0, operand/result shift regs=0.
//    - in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, out_ovf=0.
//  - FSM IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: load a/b shift regs, carry reg<=in_cin, cnt<=0, go to RUN.
//  - FSM RUN:
//    - in_ready=0.
//    - Each edge: cla sees a_sr[3:0], b_sr[3:0], carry reg.
//    - Sum nibble shifts into the top of res_sr; carry reg<=co; a_sr/b_sr shift right by 4; cnt++.
//    - When cnt==NSLICE-1 on that edge, go to DONE.
//  - FSM DONE:
//    - out_valid=1; out_sum=res_sr; out_cout=carry reg.
//    - All outputs stable while out_ready=0.
//    - On out_ready: go to IDLE, out_valid deasserted next cycle.
//  - Latency: accept edge T -> out_valid high after edge T+NSLICE (4 cycles at WIDTH=16).
//    - Throughput: one operation per NSLICE+2 cycles, minimum.
//  - in_valid outside IDLE is ignored; the source must hold its operands until in_ready.
//  - in_ready is never high while busy; no accept-on-retire overlap.
//  - Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, exact modulo 2^(WIDTH+1).
//  - Reset mid-RUN or mid-DONE: abort immediately to IDLE; the partial result is discarded, never presented.
//  - WIDTH not a multiple of 4, or < 4: elaboration-time error.
// CONFIGURATION
//  - CLA_SEQ_OVF_EN defined:
//    - out_ovf port exists.
//    - In DONE, out_ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
//    - The top operand bits are captured at accept.
//  - Undefined: no out_ovf port and no capture flops; all other behaviour identical.
// STRUCTURE
//  - Shared package cla_pkg:
//    - state enum {IDLE, RUN, DONE};
//    - CLA_SLICE_W=4 constant;
//    - count-width function clog2(NSLICE).
//  - Single sub-module: existing cla (4-bit), one instance, combinational in RUN path.
//  - Controller contains the FSM, counter, shift regs and carry reg only.
// TESTING (WIDTH=16)
//  - 0x1234 + 0x4321, cin=0 -> out_sum=0x5555, cout=0; out_valid 4 cycles after accept.
//  - 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, cout=1; carry ripples through all 4 slices.
//  - 0xA5A5 + 0x5A5A, cin=1 -> out_sum=0x0000, cout=1.
//  - Backpressure:
//    - hold out_ready=0 for 5 cycles in DONE -> out_sum, out_cout, out_valid stable, in_ready=0;
//    - in_valid pulses during the hold are not accepted.
//  - Reset mid-operation: rst_n low 1 cycle after 2 RUN edges -> IDLE, all outputs 0;
//    then 0x0005 + 0x000A -> 0x000F.
//  - CLA_SEQ_OVF_EN: 0x7FFF + 0x0001 -> out_ovf=1; 0x8000 + 0xFFFF -> out_ovf=1, cout=1;
//    0x1234 + 0x4321 -> out_ovf=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder controller.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CLA_SLICE_W = 4;

  // Counter width for n slices; never below one bit so a single-slice build still has a counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl; out_ovf exists only with CLA_SEQ_OVF_EN.
interface cla_seq_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef CLA_SEQ_OVF_EN
  logic             out_ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
`ifdef CLA_SEQ_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
`ifdef CLA_SEQ_OVF_EN
    , input out_ovf
`endif
  );

endinterface

// File: rtl/cla.sv
// Existing 4-bit carry-lookahead adder slice, purely combinational.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms, no ripple.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Adds two WIDTH-bit operands one 4-bit cla slice per clock, low slice first.
// Optional signed-overflow flag is built when CLA_SEQ_OVF_EN is defined.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_adder_ctrl_if.slave  bus
);

  localparam int unsigned    NSLICE = WIDTH / CLA_SLICE_W;
  localparam int unsigned    CNT_W  = clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  generate
    if (((WIDTH % CLA_SLICE_W) != 0) || (WIDTH < CLA_SLICE_W)) begin : g_width_chk
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               carry;

  logic               in_ready_q, out_valid_q, out_cout_q, busy_q;
  logic [WIDTH-1:0]   out_sum_q;
  logic               in_ready_d, out_valid_d, out_cout_d, busy_d;
  logic [WIDTH-1:0]   out_sum_d;
  logic               accept, step, finish, retire;

  logic [3:0]         slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   res_shift;

  cla u_cla (
    .a  (a_sr[3:0]),
    .b  (b_sr[3:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New sum nibble enters at the top so the low slice ends up at bit 0 after NSLICE steps.
  assign res_shift = (res_sr >> CLA_SLICE_W) | (WIDTH'(slice_s) << (WIDTH - CLA_SLICE_W));

`ifdef CLA_SEQ_OVF_EN
  logic a_top, b_top, ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    retire      = 1'b0;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result outputs are loaded on the final slice and zeroed once consumed.
    if (finish) begin
      out_sum_d  = res_shift;
      out_cout_d = slice_co;
`ifdef CLA_SEQ_OVF_EN
      ovf_d      = (a_top == b_top) && (slice_s[3] != a_top);
`endif
    end else if (retire) begin
      out_sum_d  = '0;
      out_cout_d = 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_d      = 1'b0;
`endif
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Datapath: operand/result shift registers, slice counter and inter-slice carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sr   <= bus.in_a;
      b_sr   <= bus.in_b;
      res_sr <= '0;
      carry  <= bus.in_cin;
    end else if (step) begin
      cnt    <= cnt + CNT_W'(1);
      a_sr   <= a_sr >> CLA_SLICE_W;
      b_sr   <= b_sr >> CLA_SLICE_W;
      res_sr <= res_shift;
      carry  <= slice_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      busy_q      <= busy_d;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  // Operand sign bits are gone from the shift registers by the last slice, so keep copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_top <= 1'b0;
      b_top <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_top <= bus.in_a[WIDTH-1];
        b_top <= bus.in_b[WIDTH-1];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl at WIDTH=16; checks out_ovf when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder_ctrl;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSLICE = WIDTH / 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic prev_v;

  cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each completed output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        else chk({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc), 32'(NSLICE));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        chk({sb[0].name, "_sum"},  32'(bus.out_sum),  32'(sb[0].sum));
        chk({sb[0].name, "_cout"}, 32'(bus.out_cout), 32'(sb[0].cout));
`ifdef CLA_SEQ_OVF_EN
        chk({sb[0].name, "_ovf"},  32'(bus.out_ovf),  32'(sb[0].ovf));
`endif
        void'(sb.pop_front());
      end
      prev_v <= bus.out_valid;
    end
  end

  // Drive one operation starting just after a rising edge; push expectation only if asked.
  task automatic send(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input bit push, input logic [15:0] es,
                      input logic ec, input logic eo);
    exp_t e;
    bit   ok;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    else if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) ok = 1'b1;
    end
    if (!ok) chk({name, "_drain_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_out_sum"},   32'(bus.out_sum),   32'd0);
    chk({name, "_out_cout"},  32'(bus.out_cout),  32'd0);
    chk({name, "_busy"},      32'(bus.busy),      32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk({name, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
`endif
  endtask

  initial begin
    bit got;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("add_5555",  16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    wait_drain("add_5555");
    send("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_drain("ripple");
    send("cin_a5",    16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_drain("cin_a5");
    send("mid_carry", 16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    wait_drain("mid_carry");

    // Backpressure: hold out_ready low for 5 cycles with stray in_valid pulses.
    bus.out_ready = 1'b0;
    send("bp", 16'h1111, 16'h2222, 1'b1, 1'b1, 16'h3334, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) chk("bp_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_a     = 16'h0F0F;
      bus.in_b     = 16'h0101;
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
      chk("bp_hold_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_hold_sum",      32'(bus.out_sum),   32'h3334);
      chk("bp_hold_cout",     32'(bus.out_cout),  32'd0);
      chk("bp_hold_in_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_hold_busy",     32'(bus.busy),      32'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("bp");
    repeat (8) @(negedge clk);
    chk("bp_no_stray_accept", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;

    // Reset after two RUN edges: operation is discarded.
    send("abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("post_reset", 16'h0005, 16'h000A, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
    wait_drain("post_reset");

    // Signed overflow cases; sum/cout always checked, ovf only when the port exists.
    send("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_drain("ovf_pos");
    send("ovf_neg",  16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_drain("ovf_neg");
    send("ovf_none", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    wait_drain("ovf_none");

    repeat (4) @(negedge clk);
    chk("final_idle_in_ready", 32'(bus.in_ready), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
